// File: rtl/fadd_arbiter.sv
// Two-requester front end for a single floating-point adder: arbitrate, run one op, hold the result until taken.
// Define FADD_ARB_RR_EN for round-robin on double requests; the default is fixed priority to requester 0.

// Unnormalised aligned adder. Flags are {nan, inf, zero, sticky}; the result keeps 3 guard bits and a carry bit.
module fadd_core (
  input  logic        sa,
  input  logic [10:0] ea,
  input  logic [52:0] fa,
  input  logic [3:0]  fla,
  input  logic        sb,
  input  logic [10:0] eb,
  input  logic [52:0] fb,
  input  logic [3:0]  flb,
  input  logic        sub,
  input  logic [52:0] nan,
  output logic [10:0] es,
  output logic [56:0] fs,
  output logic        ss,
  output logic [1:0]  fls
);
  logic        sbe, a_big, s_big, s_sml, lost, nan_hit;
  logic [55:0] ma, mb, m_big, m_sml, al;
  logic [10:0] e_big, e_sml, diff;
  logic [5:0]  sh;
  logic [56:0] mag;

  always_comb begin
    sbe = sb ^ sub;
    ma  = fla[1] ? 56'd0 : ({fa, 3'b000} | {55'd0, fla[0]});
    mb  = flb[1] ? 56'd0 : ({fb, 3'b000} | {55'd0, flb[0]});
    if (fla[1] && !flb[1]) a_big = 1'b0;
    else if (flb[1])       a_big = 1'b1;
    else                   a_big = (ea > eb) || ((ea == eb) && (fa >= fb));
    m_big = a_big ? ma  : mb;
    m_sml = a_big ? mb  : ma;
    e_big = a_big ? ea  : eb;
    e_sml = a_big ? eb  : ea;
    s_big = a_big ? sa  : sbe;
    s_sml = a_big ? sbe : sa;
    diff  = e_big - e_sml;
    // Shifts past the datapath width collapse the smaller operand into the sticky bit.
    sh    = (diff > 11'd56) ? 6'd56 : diff[5:0];
    al    = m_sml >> sh;
    lost  = (sh != 6'd0) && (|(m_sml << (6'd56 - sh)));
    al[0] = al[0] | lost;
    if (sa == sbe) begin
      mag = {1'b0, m_big} + {1'b0, al};
      ss  = s_big;
    end else if (m_big >= al) begin
      mag = {1'b0, m_big - al};
      ss  = (m_big == al) ? 1'b0 : s_big;
    end else begin
      mag = {1'b0, al - m_big};
      ss  = s_sml;
    end
    es      = e_big;
    fs      = mag;
    fls     = 2'b00;
    nan_hit = fla[3] | flb[3] | (fla[2] & flb[2] & (sa != sbe));
    if (nan_hit) begin
      es  = 11'h7FF;
      fs  = {1'b0, nan, 3'b000};
      ss  = 1'b0;
      fls = 2'b10;
    end else if (fla[2] | flb[2]) begin
      es  = 11'h7FF;
      fs  = 57'd0;
      ss  = fla[2] ? sa : sbe;
      fls = 2'b01;
    end
  end
endmodule

module fadd_arbiter #(
  parameter logic [52:0] NAN_FRAC = 53'h1_8000_0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in0_valid,
  input  logic        in1_valid,
  output logic        in0_ready,
  output logic        in1_ready,
  input  logic [68:0] in0_a,
  input  logic [68:0] in1_a,
  input  logic [68:0] in0_b,
  input  logic [68:0] in1_b,
  input  logic        in0_sub,
  input  logic        in1_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_id,
  output logic [10:0] out_es,
  output logic [56:0] out_fs,
  output logic [0:0]  out_ss,
  output logic [1:0]  out_fls,
  output logic [15:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e state_q, state_d;

  logic [68:0] a_q, a_d, b_q, b_d;
  logic        sub_q, sub_d, gnt_q, gnt_d;
  logic        out_id_q, out_id_d, out_ss_q, out_ss_d;
  logic [10:0] out_es_q, out_es_d;
  logic [56:0] out_fs_q, out_fs_d;
  logic [1:0]  out_fls_q, out_fls_d;
  logic [15:0] ops_done_q, ops_done_d;
  logic        grant, prio, accept;
  logic [10:0] add_es;
  logic [56:0] add_fs;
  logic        add_ss;
  logic [1:0]  add_fls;

`ifdef FADD_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign prio  = ptr_q;
  // Favour the requester that lost the last accept.
  assign ptr_d = accept ? ~grant : ptr_q;
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  assign prio = 1'b0;
`endif

  fadd_core u_add (
    .sa (a_q[68]), .ea(a_q[67:57]), .fa(a_q[56:4]), .fla(a_q[3:0]),
    .sb (b_q[68]), .eb(b_q[67:57]), .fb(b_q[56:4]), .flb(b_q[3:0]),
    .sub(sub_q),   .nan(NAN_FRAC),
    .es (add_es),  .fs(add_fs),     .ss(add_ss),    .fls(add_fls)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant = 1'b0;
    if (in0_valid && in1_valid) grant = prio;
    else if (in1_valid)         grant = 1'b1;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: if (rst_n) begin
        in0_ready = in0_valid && !grant;
        in1_ready = in1_valid && grant;
      end
      RESP:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = in0_ready | in1_ready;

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    gnt_d      = gnt_q;
    out_id_d   = out_id_q;
    out_es_d   = out_es_q;
    out_fs_d   = out_fs_q;
    out_ss_d   = out_ss_q;
    out_fls_d  = out_fls_q;
    ops_done_d = ops_done_q;
    if (accept) begin
      a_d   = grant ? in1_a   : in0_a;
      b_d   = grant ? in1_b   : in0_b;
      sub_d = grant ? in1_sub : in0_sub;
      gnt_d = grant;
    end
    if (state_q == EXEC) begin
      out_id_d  = gnt_q;
      out_es_d  = add_es;
      out_fs_d  = add_fs;
      out_ss_d  = add_ss;
      out_fls_d = add_fls;
    end
    if (out_valid && out_ready) ops_done_d = ops_done_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      gnt_q      <= 1'b0;
      out_id_q   <= 1'b0;
      out_es_q   <= '0;
      out_fs_q   <= '0;
      out_ss_q   <= 1'b0;
      out_fls_q  <= '0;
      ops_done_q <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      gnt_q      <= gnt_d;
      out_id_q   <= out_id_d;
      out_es_q   <= out_es_d;
      out_fs_q   <= out_fs_d;
      out_ss_q   <= out_ss_d;
      out_fls_q  <= out_fls_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign out_id   = out_id_q;
  assign out_es   = out_es_q;
  assign out_fs   = out_fs_q;
  assign out_ss   = out_ss_q;
  assign out_fls  = out_fls_q;
  assign ops_done = ops_done_q;
endmodule
